// File: rtl/strassen_pkg.sv
// Shared constants, slice indices and FSM encoding for the Strassen product/combine stage.
package strassen_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int NUM_PRODUCTS  = 7;
  localparam int NUM_SUMS      = 10;
  localparam int STEP_BITS     = 3;

  localparam logic [STEP_BITS-1:0] LAST_STEP = 3'(NUM_PRODUCTS - 1);

  // Slice positions inside the packed buses, low slice first.
  localparam int S1_IDX  = 0;
  localparam int S2_IDX  = 1;
  localparam int S3_IDX  = 2;
  localparam int S4_IDX  = 3;
  localparam int S5_IDX  = 4;
  localparam int S6_IDX  = 5;
  localparam int S7_IDX  = 6;
  localparam int S8_IDX  = 7;
  localparam int S9_IDX  = 8;
  localparam int S10_IDX = 9;

  localparam int A11_IDX = 0;
  localparam int A12_IDX = 1;
  localparam int A21_IDX = 2;
  localparam int A22_IDX = 3;

  localparam int B11_IDX = 0;
  localparam int B12_IDX = 1;
  localparam int B21_IDX = 2;
  localparam int B22_IDX = 3;

  localparam int C11_IDX = 0;
  localparam int C12_IDX = 1;
  localparam int C21_IDX = 2;
  localparam int C22_IDX = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    COMB = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/strassen_operand_sel.sv
// Picks the two multiplier operands for the current product step (P1..P7).
module strassen_operand_sel
  import strassen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [STEP_BITS-1:0]      i_step,
  input  logic [NUM_SUMS*WIDTH-1:0] i_s,
  input  logic [4*WIDTH-1:0]        i_a,
  input  logic [4*WIDTH-1:0]        i_b,
  output logic [WIDTH-1:0]          o_op_a,
  output logic [WIDTH-1:0]          o_op_b
);

  always_comb begin
    o_op_a = '0;
    o_op_b = '0;
    case (i_step)
      3'd0: begin
        o_op_a = i_a[A11_IDX*WIDTH +: WIDTH];
        o_op_b = i_s[S1_IDX*WIDTH +: WIDTH];
      end
      3'd1: begin
        o_op_a = i_s[S2_IDX*WIDTH +: WIDTH];
        o_op_b = i_b[B22_IDX*WIDTH +: WIDTH];
      end
      3'd2: begin
        o_op_a = i_s[S3_IDX*WIDTH +: WIDTH];
        o_op_b = i_b[B11_IDX*WIDTH +: WIDTH];
      end
      3'd3: begin
        o_op_a = i_a[A22_IDX*WIDTH +: WIDTH];
        o_op_b = i_s[S4_IDX*WIDTH +: WIDTH];
      end
      3'd4: begin
        o_op_a = i_s[S5_IDX*WIDTH +: WIDTH];
        o_op_b = i_s[S6_IDX*WIDTH +: WIDTH];
      end
      3'd5: begin
        o_op_a = i_s[S7_IDX*WIDTH +: WIDTH];
        o_op_b = i_s[S8_IDX*WIDTH +: WIDTH];
      end
      3'd6: begin
        o_op_a = i_s[S9_IDX*WIDTH +: WIDTH];
        o_op_b = i_s[S10_IDX*WIDTH +: WIDTH];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/strassen_product_combine.sv
// Time-multiplexes one multiplier over the seven Strassen products and combines them into C.
module strassen_product_combine
  import strassen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SUMS*WIDTH-1:0] s_in,
  input  logic [4*WIDTH-1:0]        a_in,
  input  logic [4*WIDTH-1:0]        b_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [4*WIDTH-1:0]        c_out,
  output logic                      busy
);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [NUM_SUMS*WIDTH-1:0] r_s;
  logic [4*WIDTH-1:0]        r_a;
  logic [4*WIDTH-1:0]        r_b;
  logic [STEP_BITS-1:0]      r_step;
  logic [WIDTH-1:0]          r_prod [NUM_PRODUCTS];
  logic [4*WIDTH-1:0]        r_c;
  logic                      r_out_valid;

  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_product;
  logic [WIDTH-1:0] w_c11;
  logic [WIDTH-1:0] w_c12;
  logic [WIDTH-1:0] w_c21;
  logic [WIDTH-1:0] w_c22;

  strassen_operand_sel #(.WIDTH(WIDTH)) u_operand_sel (
    .i_step (r_step),
    .i_s    (r_s),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_op_a (w_op_a),
    .o_op_b (w_op_b)
  );

  // Low WIDTH bits of a two's complement product do not depend on signedness.
  assign w_product = w_op_a * w_op_b;

  assign w_c11 = r_prod[4] + r_prod[3] - r_prod[1] + r_prod[5];
  assign w_c12 = r_prod[0] + r_prod[1];
  assign w_c21 = r_prod[2] + r_prod[3];
  assign w_c22 = r_prod[4] + r_prod[0] - r_prod[2] - r_prod[6];

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign c_out     = r_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = MUL;
      MUL:     if (r_step == LAST_STEP) w_next_state = COMB;
      COMB:    w_next_state = HOLD;
      HOLD:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_step      <= '0;
      r_c         <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < NUM_PRODUCTS; i++) r_prod[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_s    <= s_in;
            r_a    <= a_in;
            r_b    <= b_in;
            r_step <= '0;
          end
        end
        MUL: begin
          r_prod[r_step] <= w_product;
          if (r_step != LAST_STEP) r_step <= r_step + 1'b1;
        end
        COMB: begin
          r_c[C11_IDX*WIDTH +: WIDTH] <= w_c11;
          r_c[C12_IDX*WIDTH +: WIDTH] <= w_c12;
          r_c[C21_IDX*WIDTH +: WIDTH] <= w_c21;
          r_c[C22_IDX*WIDTH +: WIDTH] <= w_c22;
          r_out_valid                 <= 1'b1;
        end
        HOLD: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_strassen_product_combine.sv
// Directed-vector bench for strassen_product_combine with hand-computed C results.
module tb_strassen_product_combine;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [10*W-1:0] s_in;
  logic [4*W-1:0]  a_in;
  logic [4*W-1:0]  b_in;
  logic            out_valid;
  logic            out_ready;
  logic [4*W-1:0]  c_out;
  logic            busy;

  int vectors     = 0;
  int miscompares = 0;

  strassen_product_combine #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_in      (s_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_out     (c_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Upstream S sums are formed here so the DUT sees a consistent operand set.
  task automatic load_matrices(input int a11, input int a12, input int a21, input int a22,
                               input int b11, input int b12, input int b21, input int b22);
    int s[10];
    s[0] = b12 - b22;
    s[1] = a11 + a12;
    s[2] = a21 + a22;
    s[3] = b21 - b11;
    s[4] = a11 + a22;
    s[5] = b11 + b22;
    s[6] = a12 - a22;
    s[7] = b21 + b22;
    s[8] = a11 - a21;
    s[9] = b11 + b12;
    for (int i = 0; i < 10; i++) s_in[i*W +: W] = s[i];
    a_in = {a22[W-1:0], a21[W-1:0], a12[W-1:0], a11[W-1:0]};
    b_in = {b22[W-1:0], b21[W-1:0], b12[W-1:0], b11[W-1:0]};
  endtask

  task automatic accept_set();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (out_valid !== 1'b1) cycles = -1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    s_in      = '0;
    a_in      = '0;
    b_in      = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy got %b want 0", busy);
    end
    vectors++;
    if (c_out !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_c_out got %h want 0", c_out);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_identity_free();
    int cyc;
    out_ready = 1'b1;
    load_matrices(1, 2, 3, 4, 5, 6, 7, 8);
    accept_set();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_busy got %b want 1", busy);
    end
    wait_out(cyc);
    vectors++;
    if (cyc !== 8) begin
      miscompares++;
      $display("[TB] FAIL basic_latency got %0d want 8", cyc);
    end
    vectors++;
    if (c_out !== {32'd50, 32'd43, 32'd22, 32'd19}) begin
      miscompares++;
      $display("[TB] FAIL basic_c_out got %h want %h", c_out, {32'd50, 32'd43, 32'd22, 32'd19});
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_negation();
    int cyc;
    logic [4*W-1:0] expected;
    expected = {32'hFFFF_FFF9, 32'hFFFF_FFFC, 32'h0000_0003, 32'hFFFF_FFF7};
    out_ready = 1'b1;
    load_matrices(-1, 0, 0, -1, 9, -3, 4, 7);
    accept_set();
    wait_out(cyc);
    vectors++;
    if (cyc !== 8) begin
      miscompares++;
      $display("[TB] FAIL neg_latency got %0d want 8", cyc);
    end
    vectors++;
    if (c_out !== expected) begin
      miscompares++;
      $display("[TB] FAIL neg_c_out got %h want %h", c_out, expected);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [4*W-1:0] expected;
    expected = {32'd8, 32'd6, 32'd4, 32'd2};
    out_ready = 1'b0;
    load_matrices(2, 0, 0, 2, 1, 2, 3, 4);
    accept_set();
    wait_out(cyc);
    vectors++;
    if (c_out !== expected) begin
      miscompares++;
      $display("[TB] FAIL bp_c_out got %h want %h", c_out, expected);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || c_out !== expected) begin
        miscompares++;
        $display("[TB] FAIL bp_hold%0d got out_valid=%b in_ready=%b c_out=%h want 1/0/%h",
                 i, out_valid, in_ready, c_out, expected);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_busy_input();
    int guard;
    logic [4*W-1:0] expected;
    expected = {32'd15, 32'd1, 32'd5, 32'd7};
    out_ready = 1'b1;
    load_matrices(2, 1, 1, 3, 4, 0, -1, 5);
    accept_set();
    in_valid = 1'b1;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 20) begin
      load_matrices(guard + 11, -guard, 7, guard * 3, 100, guard - 5, 13, -9);
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL busy_in_ready step%0d got %b want 0", guard, in_ready);
      end
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    vectors++;
    if (guard !== 8) begin
      miscompares++;
      $display("[TB] FAIL busy_latency got %0d want 8", guard);
    end
    vectors++;
    if (c_out !== expected) begin
      miscompares++;
      $display("[TB] FAIL busy_c_out got %h want %h", c_out, expected);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_idle got %b want 0", busy);
    end
  endtask

  task automatic test_reset_midop();
    int cyc;
    out_ready = 1'b1;
    load_matrices(-1, 0, 0, -1, 9, -3, 4, 7);
    accept_set();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midop_busy_before got %b want 1", busy);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || c_out !== '0) begin
      miscompares++;
      $display("[TB] FAIL midop_reset got in_ready=%b out_valid=%b busy=%b c_out=%h want 1/0/0/0",
               in_ready, out_valid, busy, c_out);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    load_matrices(1, 2, 3, 4, 5, 6, 7, 8);
    accept_set();
    wait_out(cyc);
    vectors++;
    if (cyc !== 8) begin
      miscompares++;
      $display("[TB] FAIL midop_latency got %0d want 8", cyc);
    end
    vectors++;
    if (c_out !== {32'd50, 32'd43, 32'd22, 32'd19}) begin
      miscompares++;
      $display("[TB] FAIL midop_c_out got %h want %h", c_out, {32'd50, 32'd43, 32'd22, 32'd19});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    int cyc;
    out_ready = 1'b1;
    s_in = '0;
    a_in = '0;
    b_in = '0;
    s_in[0 +: W] = 32'h0001_0000;
    a_in[0 +: W] = 32'h0001_0000;
    accept_set();
    wait_out(cyc);
    vectors++;
    if (cyc !== 8) begin
      miscompares++;
      $display("[TB] FAIL wrap_latency got %0d want 8", cyc);
    end
    vectors++;
    if (c_out !== '0) begin
      miscompares++;
      $display("[TB] FAIL wrap_c_out got %h want 0", c_out);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_identity_free();
    test_negation();
    test_backpressure();
    test_busy_input();
    test_reset_midop();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
